// File: rtl/autosym_pla_eval.sv
// First-match cube-table (PLA) evaluator over a GF(2)-transformed operand, one cube per cycle.
// Define AUTOSYM_XFORM_EN to build the programmable transform rows; otherwise z = x.
module autosym_pla_eval #(
  parameter int N_IN   = 10,
  parameter int N_CUBE = 64,
  localparam int CW    = (N_CUBE > 1) ? $clog2(N_CUBE) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic            cfg_sel,
  input  logic [CW-1:0]   cfg_addr,
  input  logic [N_IN-1:0] cfg_mask,
  input  logic [N_IN-1:0] cfg_val,
  input  logic            cfg_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            y0,
  output logic [CW-1:0]   hit_idx
);

  typedef enum logic [1:0] {S_IDLE, S_XFORM, S_SCAN, S_HOLD} state_t;

  localparam logic [CW-1:0] LAST_K = CW'(N_CUBE - 1);

  state_t            r_state;
  logic [N_IN-1:0]   r_x;
  logic [N_IN-1:0]   r_z;
  logic [CW-1:0]     r_k;
  logic              r_out_valid;
  logic              r_y0;
  logic [CW-1:0]     r_hit_idx;

  logic [N_IN-1:0]   r_cube_mask [N_CUBE];
  logic [N_IN-1:0]   r_cube_val  [N_CUBE];
  logic [N_CUBE-1:0] r_cube_en;

  logic              w_cfg_ok;
  logic              w_cube_we;
  logic [N_IN-1:0]   w_z;
  logic              w_match;

  // Configuration is only honoured while the engine is idle, so a scan never sees a torn table.
  assign w_cfg_ok  = cfg_we && (r_state == S_IDLE);
  assign w_cube_we = w_cfg_ok && !cfg_sel;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign y0        = r_y0;
  assign hit_idx   = r_hit_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CUBE; i++) begin
        r_cube_mask[i] <= '0;
        r_cube_val[i]  <= '0;
      end
      r_cube_en <= '0;
    end else if (w_cube_we) begin
      r_cube_mask[cfg_addr] <= cfg_mask;
      r_cube_val[cfg_addr]  <= cfg_val;
      r_cube_en[cfg_addr]   <= cfg_en;
    end
  end

`ifdef AUTOSYM_XFORM_EN
  localparam int              RW      = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [N_IN-1:0] ONE_HOT = N_IN'(1);

  logic [N_IN-1:0] r_row [N_IN];
  logic [RW-1:0]   w_row_addr;
  logic            w_row_we;

  // Only the low address bits select a row; indices past the last row are dropped.
  assign w_row_addr = RW'(cfg_addr);
  assign w_row_we   = w_cfg_ok && cfg_sel && ({1'b0, w_row_addr} < (RW + 1)'(N_IN));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        r_row[i] <= ONE_HOT << i;
      end
    end else if (w_row_we) begin
      r_row[w_row_addr] <= cfg_mask;
    end
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_xform
    assign w_z[gi] = ^(r_x & r_row[gi]);
  end
`else
  assign w_z = r_x;
`endif

  // A zero care-mask makes an enabled cube a tautology.
  assign w_match = r_cube_en[r_k] && (((r_z ^ r_cube_val[r_k]) & r_cube_mask[r_k]) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_z         <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_y0        <= 1'b0;
      r_hit_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x     <= x;
            r_state <= S_XFORM;
          end
        end
        S_XFORM: begin
          r_z     <= w_z;
          r_k     <= '0;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (w_match) begin
            r_y0        <= 1'b1;
            r_hit_idx   <= r_k;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else if (r_k == LAST_K) begin
            r_y0        <= 1'b0;
            r_hit_idx   <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
